// File: rtl/timer_switch_pkg.sv
// rtl/timer_switch_pkg.sv - shared types and defaults for the staircase-light timer
package timer_switch_pkg;

  typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;

  localparam int DEFAULT_ON_CYCLES = 20;

  // Timer width for a given interval; never narrower than one bit so ON_CYCLES=1 still builds.
  function automatic int timer_width(input int on_cycles);
    return (on_cycles > 1) ? $clog2(on_cycles) : 1;
  endfunction

endpackage

// File: rtl/timer_switch_rise_detect.sv
// rtl/timer_switch_rise_detect.sv - one-cycle rising-edge pulse on a synchronous level input
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember last cycle's level; reset to 0 so a level already high at reset release counts as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/timer_switch.sv
// rtl/timer_switch.sv - staircase-light timer top; optional assertions under TIMER_SWITCH_SVA_EN
module timer_switch
  import timer_switch_pkg::*;
#(
  parameter int ON_CYCLES = DEFAULT_ON_CYCLES
) (
  input  logic clock_1Hz,
  input  logic reset_n,
  input  logic btn,
  output logic light
);

  localparam int TW = timer_width(ON_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(ON_CYCLES - 1);

  logic          rise;
  state_t        state;
  state_t        state_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic          light_q;

  rise_detect u_rise_detect (
    .clk   (clock_1Hz),
    .rst_n (reset_n),
    .d     (btn),
    .rise  (rise)
  );

  // Next state: any rise reloads the full interval; otherwise count down and drop out at zero.
  always_comb begin
    state_d = state;
    timer_d = timer;
    if (rise) begin
      state_d = ON;
      timer_d = RELOAD;
    end else if (state == ON) begin
      if (timer != '0) begin
        timer_d = timer - TW'(1);
      end else begin
        state_d = OFF;
        timer_d = '0;
      end
    end else begin
      timer_d = '0;
    end
  end

  // State, timer and lamp registers; reset clears the lamp immediately and discards any interval.
  always_ff @(posedge clock_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= OFF;
      timer   <= '0;
      light_q <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      light_q <= (state_d == ON);
    end
  end

  assign light = light_q;

`ifdef TIMER_SWITCH_SVA_EN
  a_rise_holds : assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    rise |=> light [* ON_CYCLES]);

  a_fall_origin : assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    $fell(light) |-> $past(btn, ON_CYCLES + 1) && !$past(btn, ON_CYCLES + 2));

  a_off_timer_zero : assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    (state == OFF) |-> (timer == '0));

  a_light_state : assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    light == (state == ON));
`else
`endif

endmodule

// File: tb/tb_timer_switch.sv
// tb/tb_timer_switch.sv - directed self-checking bench for timer_switch
module tb_timer_switch;
  import timer_switch_pkg::*;

  localparam int N = 20;

  logic clock_1Hz = 1'b0;
  logic reset_n   = 1'b0;
  logic btn       = 1'b0;
  logic light;

  int total = 0;
  int bad   = 0;

  timer_switch #(.ON_CYCLES(N)) dut (
    .clock_1Hz (clock_1Hz),
    .reset_n   (reset_n),
    .btn       (btn),
    .light     (light)
  );

  always #5 clock_1Hz = ~clock_1Hz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock_1Hz);
    @(negedge clock_1Hz);
  endtask

  // Called right after the reload edge: expect N lit cycles with a falling timer, then OFF.
  // btn stays high for 'hold' further edges to model a held button.
  task automatic expect_interval(input string tag, input int hold);
    for (int i = 0; i < N; i++) begin
      check({tag, "_light"}, 32'(light), 32'd1);
      check({tag, "_timer"}, 32'(dut.timer), 32'(N - 1 - i));
      btn = (i < hold);
      tick();
    end
    check({tag, "_fall_light"}, 32'(light), 32'd0);
    check({tag, "_fall_state"}, 32'(dut.state), 32'(OFF));
    check({tag, "_fall_timer"}, 32'(dut.timer), 32'd0);
  endtask

  initial begin
    // 1. reset and idle
    @(negedge clock_1Hz);
    check("rst_light", 32'(light), 32'd0);
    check("rst_state", 32'(dut.state), 32'(OFF));
    check("rst_timer", 32'(dut.timer), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_light", 32'(light), 32'd0);
      check("idle_timer", 32'(dut.timer), 32'd0);
    end

    // 2. single one-cycle press
    btn = 1'b1;
    tick();
    expect_interval("single", 0);

    // 3. retrigger ten cycles after the first press
    btn = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("retrig_first_light", 32'(light), 32'd1);
      check("retrig_first_timer", 32'(dut.timer), 32'(N - 1 - i));
      btn = 1'b0;
      tick();
    end
    btn = 1'b1;
    tick();
    expect_interval("retrig", 0);

    // 4. long press of five cycles
    btn = 1'b1;
    tick();
    expect_interval("long", 4);

    // 5. press exactly when timer reaches zero
    btn = 1'b1;
    tick();
    for (int i = 0; i < N - 1; i++) begin
      btn = 1'b0;
      tick();
    end
    check("bnd_zero_timer", 32'(dut.timer), 32'd0);
    check("bnd_zero_light", 32'(light), 32'd1);
    btn = 1'b1;
    tick();
    expect_interval("bnd", 0);

    // 6. reset in the middle of an interval
    btn = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      btn = 1'b0;
      tick();
    end
    check("mid_timer7", 32'(dut.timer), 32'd7);
    check("mid_light_pre", 32'(light), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_light", 32'(light), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(OFF));
    check("mid_rst_timer", 32'(dut.timer), 32'd0);
    @(negedge clock_1Hz);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_after_light", 32'(light), 32'd0);
    end

    // 7. button already high when reset is released
    reset_n = 1'b0;
    btn     = 1'b1;
    tick();
    check("rstbtn_held_light", 32'(light), 32'd0);
    reset_n = 1'b1;
    tick();
    expect_interval("rstbtn", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
